// File: rtl/nist_freq_blk_tester.sv
// nist_freq_blk_tester
// Streaming NIST SP 800-22 frequency (monobit) and block-frequency tester.
// Accepts one bit per rnd_valid/rnd_ready handshake. After n bits it spends
// a single EVAL cycle updating both active-low verdicts, pulsing done and
// bumping the saturating failure counter. It can run single-shot or continuously.
//
// Handshake: a bit is consumed on a rising edge where rnd_valid && rnd_ready.
// rnd_ready is high only in RUN. Bits offered in IDLE or EVAL are not stored.
// A stalled rnd_valid freezes every accumulator.
module nist_freq_blk_tester #(
  parameter int N_LOG2    = 10,
  parameter int M_LOG2    = 7,
  parameter int S_MAX     = 82,
  parameter int SUMSQ_MAX = 2571,
  parameter int FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              rnd_in,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  output logic              n_pass_freq,
  output logic              n_pass_blk,
  output logic              busy,
  output logic              done,
  output logic [FCNT_W-1:0] fail_cnt,
  output logic [1:0]        dbg_state
);

  // Accumulator widths
  localparam int S_W  = N_LOG2 + 2;           // signed running sum S
  localparam int C_W  = M_LOG2 + 1;           // ones count within a block
  localparam int D_W  = M_LOG2 + 2;           // block term d = 2c - M
  localparam int SQ_W = 2 * M_LOG2 + 1;       // d^2, at most M^2
  localparam int SS_W = M_LOG2 + N_LOG2 + 1;  // sum of d^2 over all blocks

  localparam logic [D_W-1:0]  M_L       = D_W'(1) << M_LOG2;
  localparam logic [S_W-1:0]  S_ONE     = S_W'(1);
  localparam logic [S_W-1:0]  S_MONE    = '1;
  localparam logic [S_W-1:0]  S_MAX_L   = S_W'(S_MAX);
  localparam logic [SS_W-1:0] SUMSQ_L   = SS_W'(SUMSQ_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EVAL = 2'd2
  } state_t;

  state_t            r_state;
  logic [N_LOG2-1:0] r_k;
  logic [S_W-1:0]    r_s;          // two's complement
  logic [C_W-1:0]    r_c;
  logic [SS_W-1:0]   r_sumsq;
  logic [S_W-1:0]    r_s_eval;
  logic [SS_W-1:0]   r_sumsq_eval;

  logic              w_accept;
  logic              w_blk_end;
  logic              w_last;
  logic [C_W-1:0]    w_c_next;
  logic [D_W-1:0]    w_2c;
  logic [D_W-1:0]    w_d;
  logic [D_W-1:0]    w_d_abs;
  logic [SQ_W-1:0]   w_d_abs_w;
  logic [SQ_W-1:0]   w_d_sq;
  logic [SS_W-1:0]   w_sumsq_next;
  logic [S_W-1:0]    w_s_next;
  logic [S_W-1:0]    w_s_abs;
  logic              w_freq_fail;
  logic              w_blk_fail;

  assign w_accept  = (r_state == ST_RUN) && rnd_valid;
  assign w_blk_end = &r_k[M_LOG2-1:0];
  assign w_last    = &r_k;

  // Block term includes the bit being accepted, so the closing block uses its full count.
  assign w_c_next  = r_c + {{(C_W-1){1'b0}}, rnd_in};
  assign w_2c      = {w_c_next, 1'b0};
  assign w_d       = w_2c - M_L;
  assign w_d_abs   = w_d[D_W-1] ? (D_W'(0) - w_d) : w_d;
  assign w_d_abs_w = SQ_W'(w_d_abs);
  assign w_d_sq    = w_d_abs_w * w_d_abs_w;

  assign w_sumsq_next = w_blk_end ? (r_sumsq + SS_W'(w_d_sq)) : r_sumsq;
  assign w_s_next     = r_s + (rnd_in ? S_ONE : S_MONE);

  // Verdicts are computed from the captured end-of-sequence values.
  assign w_s_abs     = r_s_eval[S_W-1] ? (S_W'(0) - r_s_eval) : r_s_eval;
  assign w_freq_fail = (w_s_abs > S_MAX_L);
  assign w_blk_fail  = (r_sumsq_eval > SUMSQ_L);

  assign rnd_ready = (r_state == ST_RUN);
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

  // Per-bit accumulation. The last bit moves the totals into the eval registers and clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k          <= '0;
      r_s          <= '0;
      r_c          <= '0;
      r_sumsq      <= '0;
      r_s_eval     <= '0;
      r_sumsq_eval <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_s_eval     <= w_s_next;
        r_sumsq_eval <= w_sumsq_next;
        r_k          <= '0;
        r_s          <= '0;
        r_c          <= '0;
        r_sumsq      <= '0;
      end else begin
        r_k     <= r_k + N_LOG2'(1);
        r_s     <= w_s_next;
        r_sumsq <= w_sumsq_next;
        r_c     <= w_blk_end ? '0 : w_c_next;
      end
    end
  end

  // Control FSM with the registered verdicts, done strobe and failure counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      n_pass_freq <= 1'b1;
      n_pass_blk  <= 1'b1;
      done        <= 1'b0;
      fail_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_accept && w_last) r_state <= ST_EVAL;
        end
        ST_EVAL: begin
          n_pass_freq <= w_freq_fail;
          n_pass_blk  <= w_blk_fail;
          done        <= 1'b1;
          if ((w_freq_fail || w_blk_fail) && (fail_cnt != '1))
            fail_cnt <= fail_cnt + FCNT_W'(1);
          r_state <= cont ? ST_RUN : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nist_freq_blk_tester.sv
// Bench for nist_freq_blk_tester: a reference model computes S and the sum of
// squares from each driven sequence. It pushes the expected verdicts and
// counters to exp_q. A done monitor pops the entries and compares them with
// both DUT instances (FCNT_W=8 and FCNT_W=2).
module tb_nist_freq_blk_tester;

  localparam int S_MAX     = 82;
  localparam int SUMSQ_MAX = 2571;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cont;
  logic rnd_in;
  logic rnd_valid;

  logic       rnd_ready, n_pass_freq, n_pass_blk, busy, done;
  logic [7:0] fail_cnt;
  logic [1:0] dbg_state;

  logic       rnd_ready2, n_pass_freq2, n_pass_blk2, busy2, done2;
  logic [1:0] fail_cnt2;
  logic [1:0] dbg_state2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int m_fcnt = 0;
  int m_fcnt2 = 0;

  // {freq_fail, blk_fail, fail_cnt[7:0], fail_cnt2[1:0]}
  logic [11:0] exp_q[$];
  logic [11:0] last_exp;
  logic [11:0] mon_e;
  int          done_cyc_q[$];

  nist_freq_blk_tester dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .rnd_in(rnd_in),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .n_pass_freq(n_pass_freq),
    .n_pass_blk(n_pass_blk), .busy(busy), .done(done), .fail_cnt(fail_cnt),
    .dbg_state(dbg_state)
  );

  nist_freq_blk_tester #(.FCNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .rnd_in(rnd_in),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready2), .n_pass_freq(n_pass_freq2),
    .n_pass_blk(n_pass_blk2), .busy(busy2), .done(done2), .fail_cnt(fail_cnt2),
    .dbg_state(dbg_state2)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout cyc=%0d required=finish", cyc);
    $fatal(1);
  end

  // Scoreboard: every done strobe pops one expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cyc_q.push_back(cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done got=done required=no_done cyc=%0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (n_pass_freq !== mon_e[11]) begin
          n_err++; $display("FAIL sb_n_pass_freq got=%b exp=%b", n_pass_freq, mon_e[11]);
        end
        n_cmp++;
        if (n_pass_blk !== mon_e[10]) begin
          n_err++; $display("FAIL sb_n_pass_blk got=%b exp=%b", n_pass_blk, mon_e[10]);
        end
        n_cmp++;
        if (fail_cnt !== mon_e[9:2]) begin
          n_err++; $display("FAIL sb_fail_cnt got=%0d exp=%0d", fail_cnt, mon_e[9:2]);
        end
        n_cmp++;
        if (fail_cnt2 !== mon_e[1:0]) begin
          n_err++; $display("FAIL sb_fail_cnt2 got=%0d exp=%0d", fail_cnt2, mon_e[1:0]);
        end
        n_cmp++;
        if (done2 !== 1'b1 || n_pass_freq2 !== mon_e[11] || n_pass_blk2 !== mon_e[10]) begin
          n_err++; $display("FAIL sb_dut2_verdict got=%b%b%b exp=1%b%b",
                            done2, n_pass_freq2, n_pass_blk2, mon_e[11], mon_e[10]);
        end
      end
    end
  end

  // ---------------- pattern builders and model ----------------
  function automatic logic [1023:0] pat_blocks(input int cnts[8]);
    logic [1023:0] p;
    p = '0;
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < 128; j++)
        if (j < cnts[b]) p[b*128 + j] = 1'b1;
    return p;
  endfunction

  function automatic logic [1023:0] pat_alt();
    logic [1023:0] p;
    for (int i = 0; i < 1024; i++) p[i] = ((i % 2) == 0);
    return p;
  endfunction

  task automatic push_model(input logic [1023:0] bits);
    int s, ss, c, d;
    logic ff, bf;
    s = 0; ss = 0;
    for (int b = 0; b < 8; b++) begin
      c = 0;
      for (int j = 0; j < 128; j++) c += int'(bits[b*128 + j]);
      d = 2 * c - 128;
      s += d;
      ss += d * d;
    end
    ff = (s > S_MAX) || (s < -S_MAX);
    bf = (ss > SUMSQ_MAX);
    if (ff || bf) begin
      if (m_fcnt < 255) m_fcnt++;
      if (m_fcnt2 < 3) m_fcnt2++;
    end
    last_exp = {ff, bf, 8'(m_fcnt), 2'(m_fcnt2)};
    exp_q.push_back(last_exp);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; rnd_in = 1'b0; cont = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_fcnt = 0; m_fcnt2 = 0;
    exp_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    n_cmp++;
    if (rnd_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_start got=%b exp=1", rnd_ready);
    end
  endtask

  task automatic drive_seq(input logic [1023:0] bits, input int gap, input int drop_at);
    int idx, budget;
    idx = 0; budget = 0;
    push_model(bits);
    while (idx < 1024 && budget < 8000) begin
      if (idx == drop_at) cont = 1'b0;
      if (gap > 0 && int'($urandom_range(0, 99)) < gap) begin
        rnd_valid = 1'b0; rnd_in = 1'($urandom_range(0, 1));
      end else begin
        rnd_valid = 1'b1; rnd_in = bits[idx];
      end
      if (rnd_valid && rnd_ready) idx++;
      @(negedge clk);
      budget++;
    end
    rnd_valid = 1'b0;
    if (idx < 1024) begin
      n_cmp++; n_err++;
      $display("FAIL drive_timeout accepted=%0d required=1024", idx);
    end
  endtask

  task automatic drive_partial(input int nbits, input int gap);
    int idx, budget;
    idx = 0; budget = 0;
    while (idx < nbits && budget < 4000) begin
      rnd_valid = (int'($urandom_range(0, 99)) >= gap);
      rnd_in = 1'($urandom_range(0, 1));
      if (rnd_valid && rnd_ready) idx++;
      @(negedge clk);
      budget++;
    end
    rnd_valid = 1'b0;
  endtask

  task automatic finish_run();
    int b;
    b = 0;
    while (busy && b < 20) begin @(negedge clk); b++; end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL run_end_busy got=%b exp=0", busy);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL pending_results got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic run_single(input logic [1023:0] bits, input int gap);
    do_start();
    drive_seq(bits, gap, -1);
    n_cmp++;
    if (rnd_ready !== 1'b0 || dbg_state !== 2'd2) begin
      n_err++; $display("FAIL eval_cycle ready=%b state=%0d exp ready=0 state=2", rnd_ready, dbg_state);
    end
    finish_run();
    n_cmp++;
    if ({n_pass_freq, n_pass_blk, fail_cnt} !== last_exp[11:2]) begin
      n_err++; $display("FAIL held_verdict got=%b%b/%0d exp=%b%b/%0d", n_pass_freq, n_pass_blk,
                        fail_cnt, last_exp[11], last_exp[10], last_exp[9:2]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (n_pass_freq !== 1'b1 || n_pass_blk !== 1'b1) begin
      n_err++; $display("FAIL reset_verdicts got=%b%b exp=11", n_pass_freq, n_pass_blk);
    end
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || rnd_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl got done=%b busy=%b ready=%b exp=000", done, busy, rnd_ready);
    end
    n_cmp++;
    if (fail_cnt !== 8'd0 || fail_cnt2 !== 2'd0) begin
      n_err++; $display("FAIL reset_fail_cnt got=%0d/%0d exp=0/0", fail_cnt, fail_cnt2);
    end
    n_cmp++;
    if (dbg_state !== 2'd0 || dbg_state2 !== 2'd0 || busy2 !== 1'b0 || rnd_ready2 !== 1'b0) begin
      n_err++; $display("FAIL reset_state got=%0d/%0d exp=0/0", dbg_state, dbg_state2);
    end
  endtask

  task automatic test_all_ones();
    do_reset();
    run_single('1, 0);
    n_cmp++;
    if (done_cyc_q.size() != 1 || (done_cyc_q.size() == 1 && done_cyc_q[0] - start_cyc != 1025)) begin
      n_err++; $display("FAIL ones_done_latency got=%0d exp=1025",
                        (done_cyc_q.size() > 0) ? done_cyc_q[0] - start_cyc : -1);
    end
    n_cmp++;
    if (n_pass_freq !== 1'b1 || n_pass_blk !== 1'b1 || fail_cnt !== 8'd1) begin
      n_err++; $display("FAIL ones_result got=%b%b/%0d exp=11/1", n_pass_freq, n_pass_blk, fail_cnt);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL done_width got=%b exp=0", done);
    end
  endtask

  task automatic test_alternating();
    do_reset();
    run_single(pat_alt(), 0);
    n_cmp++;
    if (n_pass_freq !== 1'b0 || n_pass_blk !== 1'b0 || fail_cnt !== 8'd0) begin
      n_err++; $display("FAIL alt_result got=%b%b/%0d exp=00/0", n_pass_freq, n_pass_blk, fail_cnt);
    end
  endtask

  task automatic test_s_boundary();
    int c[8];
    do_reset();
    c = '{69, 69, 69, 69, 69, 69, 69, 70};   // S=82, sumsq=844
    run_single(pat_blocks(c), 0);
    n_cmp++;
    if (n_pass_freq !== 1'b0 || n_pass_blk !== 1'b0) begin
      n_err++; $display("FAIL s82_pass got=%b%b exp=00", n_pass_freq, n_pass_blk);
    end
    c = '{69, 69, 69, 69, 69, 69, 70, 70};   // S=84
    run_single(pat_blocks(c), 0);
    n_cmp++;
    if (n_pass_freq !== 1'b1 || n_pass_blk !== 1'b0 || fail_cnt !== 8'd1) begin
      n_err++; $display("FAIL s84_fail got=%b%b/%0d exp=10/1", n_pass_freq, n_pass_blk, fail_cnt);
    end
    c = '{69, 69, 69, 69, 69, 69, 70, 71};   // S=86
    run_single(pat_blocks(c), 10);
  endtask

  task automatic test_sumsq_boundary();
    int c[8];
    do_reset();
    c = '{89, 68, 65, 64, 64, 64, 64, 64};   // sumsq=2568
    run_single(pat_blocks(c), 0);
    n_cmp++;
    if (n_pass_blk !== 1'b0) begin
      n_err++; $display("FAIL sumsq2568_pass got=%b exp=0", n_pass_blk);
    end
    c = '{89, 67, 67, 64, 64, 64, 64, 64};   // sumsq=2572
    run_single(pat_blocks(c), 0);
    n_cmp++;
    if (n_pass_blk !== 1'b1 || n_pass_freq !== 1'b0) begin
      n_err++; $display("FAIL sumsq2572_fail got=%b%b exp=01", n_pass_freq, n_pass_blk);
    end
  endtask

  task automatic test_block_alt();
    int c[8];
    do_reset();
    c = '{128, 0, 128, 0, 128, 0, 128, 0};
    run_single(pat_blocks(c), 0);
    n_cmp++;
    if (n_pass_freq !== 1'b0 || n_pass_blk !== 1'b1) begin
      n_err++; $display("FAIL blkalt_result got=%b%b exp=01", n_pass_freq, n_pass_blk);
    end
  endtask

  task automatic test_back_to_back();
    int c[8];
    do_reset();
    cont = 1'b1;
    c = '{69, 69, 69, 69, 69, 69, 69, 70};
    do_start();
    drive_seq(pat_alt(), 0, -1);
    n_cmp++;
    if (rnd_ready !== 1'b0) begin
      n_err++; $display("FAIL b2b_eval1_ready got=%b exp=0", rnd_ready);
    end
    drive_seq('1, 0, -1);
    n_cmp++;
    if (rnd_ready !== 1'b0) begin
      n_err++; $display("FAIL b2b_eval2_ready got=%b exp=0", rnd_ready);
    end
    drive_seq(pat_blocks(c), 0, 500);
    n_cmp++;
    if (rnd_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_eval3 got ready=%b busy=%b exp ready=0 busy=1", rnd_ready, busy);
    end
    finish_run();
    n_cmp++;
    if (done_cyc_q.size() != 3) begin
      n_err++; $display("FAIL b2b_done_count got=%0d exp=3", done_cyc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (done_cyc_q[i] - start_cyc != 1025 * (i + 1)) begin
          n_err++; $display("FAIL b2b_done_time%0d got=%0d exp=%0d", i, done_cyc_q[i] - start_cyc, 1025 * (i + 1));
        end
      end
    end
    n_cmp++;
    if (fail_cnt !== 8'd1 || n_pass_freq !== 1'b0 || n_pass_blk !== 1'b0) begin
      n_err++; $display("FAIL b2b_final got=%b%b/%0d exp=00/1", n_pass_freq, n_pass_blk, fail_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    int c[8];
    do_reset();
    do_start();
    drive_partial(500, 25);
    do_reset();
    n_cmp++;
    if (busy !== 1'b0 || rnd_ready !== 1'b0 || done !== 1'b0 || n_pass_freq !== 1'b1 ||
        n_pass_blk !== 1'b1 || fail_cnt !== 8'd0) begin
      n_err++; $display("FAIL midrun_reset_outputs got busy=%b ready=%b done=%b v=%b%b cnt=%0d exp=0,0,0,11,0",
                        busy, rnd_ready, done, n_pass_freq, n_pass_blk, fail_cnt);
    end
    // zeros offered in IDLE must be dropped
    rnd_valid = 1'b1; rnd_in = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (rnd_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL idle_ready got=%b exp=0", rnd_ready);
    end
    c = '{69, 69, 69, 69, 69, 69, 69, 70};
    run_single(pat_blocks(c), 25);
    n_cmp++;
    if (n_pass_freq !== 1'b0 || n_pass_blk !== 1'b0) begin
      n_err++; $display("FAIL after_drop_s82 got=%b%b exp=00", n_pass_freq, n_pass_blk);
    end
    rnd_valid = 1'b1; rnd_in = 1'b0;
    repeat (5) @(negedge clk);
    run_single('1, 25);
    n_cmp++;
    if (fail_cnt !== 8'd1 || n_pass_freq !== 1'b1 || n_pass_blk !== 1'b1) begin
      n_err++; $display("FAIL after_drop_ones got=%b%b/%0d exp=11/1", n_pass_freq, n_pass_blk, fail_cnt);
    end
  endtask

  task automatic test_fail_sat();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      run_single('1, 0);
      n_cmp++;
      if (fail_cnt2 !== 2'((i > 3) ? 3 : i) || fail_cnt !== 8'(i)) begin
        n_err++; $display("FAIL fail_sat_run%0d got=%0d/%0d exp=%0d/%0d", i, fail_cnt, fail_cnt2,
                          i, (i > 3) ? 3 : i);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; rnd_in = 1'b0; rnd_valid = 1'b0;
    test_reset();
    test_all_ones();
    test_alternating();
    test_s_boundary();
    test_sumsq_boundary();
    test_block_alt();
    test_back_to_back();
    test_reset_midrun();
    test_fail_sat();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL final_queue got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
